piece_rotate_ctrl: RTL

Active-piece register and rotation executor. It holds the falling piece's type, four cell coordinates and rotation index, and drives them to the rotation-validity checker. It accepts rotate requests, samples the checker's validity flags, and commits the rotated coordinates only when the rotation is legal. Spawn loads a new piece from a fixed shape table.

---
 rtl/piece_rotate_ctrl_if.sv | 40 ++++
 rtl/piece_rotate_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/piece_rotate_ctrl_if.sv
// Bus bundle between the active-piece controller and its environment: spawn and
// rotate requests, checker validity flags, and the registered piece state.
interface piece_rotate_ctrl_if;
    logic       spawn;
    logic [3:0] spawn_block;
    logic       rot_cw;
    logic       rot_ccw;
    logic       valid_cw;
    logic       valid_ccw;
    logic [3:0] current_block;
    logic [9:0] ctrl_x1;
    logic [9:0] ctrl_x2;
    logic [9:0] ctrl_x3;
    logic [9:0] ctrl_x4;
    logic [9:0] ctrl_y1;
    logic [9:0] ctrl_y2;
    logic [9:0] ctrl_y3;
    logic [9:0] ctrl_y4;
    logic [1:0] rot_state;
    logic       piece_active;
    logic       busy;
    logic       done;
    logic       accepted;

    // Requester / checker side.
    modport master (
        output spawn, spawn_block, rot_cw, rot_ccw, valid_cw, valid_ccw,
        input  current_block, ctrl_x1, ctrl_x2, ctrl_x3, ctrl_x4,
        input  ctrl_y1, ctrl_y2, ctrl_y3, ctrl_y4,
        input  rot_state, piece_active, busy, done, accepted
    );

    // Controller side.
    modport slave (
        input  spawn, spawn_block, rot_cw, rot_ccw, valid_cw, valid_ccw,
        output current_block, ctrl_x1, ctrl_x2, ctrl_x3, ctrl_x4,
        output ctrl_y1, ctrl_y2, ctrl_y3, ctrl_y4,
        output rot_state, piece_active, busy, done, accepted
    );
endinterface

// File: rtl/piece_rotate_ctrl.sv
// Active-piece register and rotation executor. Holds the falling piece's code,
// four cell coordinates and rotation index. Rotation requests take one CHECK
// cycle in which the external checker's flag and an on-board test decide commit.
module piece_rotate_ctrl #(
    parameter int unsigned BOARD_W = 10,
    parameter int unsigned BOARD_H = 20,
    parameter int unsigned SPAWN_X = 3
) (
    input  logic               clk,
    input  logic               rst,
    piece_rotate_ctrl_if.slave bus
);
    // Piece codes; 0 means no piece.
    localparam logic [3:0] O_BLOCK = 4'd1;
    localparam logic [3:0] I_BLOCK = 4'd2;
    localparam logic [3:0] L_BLOCK = 4'd3;
    localparam logic [3:0] J_BLOCK = 4'd4;
    localparam logic [3:0] S_BLOCK = 4'd5;
    localparam logic [3:0] Z_BLOCK = 4'd6;
    localparam logic [3:0] T_BLOCK = 4'd7;

    localparam logic [9:0] SX  = 10'(SPAWN_X);
    localparam logic [9:0] BW  = 10'(BOARD_W);
    localparam logic [9:0] BH  = 10'(BOARD_H);

    typedef enum logic [0:0] {StIdle, StCheck} state_e;

    state_e     r_state;
    logic [9:0] r_x [4];
    logic [9:0] r_y [4];
    logic [3:0] r_block;
    logic [1:0] r_rot;
    logic       r_active;
    logic       r_busy;
    logic       r_done;
    logic       r_accepted;
    logic       r_dir_cw;

    logic [1:0] w_rel_x [4];
    logic [1:0] w_rel_y [4];
    logic       w_spawn_known;
    logic [9:0] w_cand_x [4];
    logic [9:0] w_cand_y [4];
    logic       w_in_bounds;
    logic       w_valid_sel;
    logic       w_req;

    // Spawn shape table: cell offsets relative to (SPAWN_X, 0); cell 2 is the pivot.
    always_comb begin
        w_spawn_known = 1'b1;
        w_rel_x = '{2'd0, 2'd0, 2'd0, 2'd0};
        w_rel_y = '{2'd0, 2'd0, 2'd0, 2'd0};
        case (bus.spawn_block)
            O_BLOCK: begin
                w_rel_x = '{2'd1, 2'd2, 2'd1, 2'd2};
                w_rel_y = '{2'd0, 2'd0, 2'd1, 2'd1};
            end
            I_BLOCK: begin
                w_rel_x = '{2'd0, 2'd1, 2'd2, 2'd3};
                w_rel_y = '{2'd0, 2'd0, 2'd0, 2'd0};
            end
            T_BLOCK: begin
                w_rel_x = '{2'd0, 2'd1, 2'd2, 2'd1};
                w_rel_y = '{2'd1, 2'd1, 2'd1, 2'd0};
            end
            L_BLOCK: begin
                w_rel_x = '{2'd0, 2'd1, 2'd2, 2'd2};
                w_rel_y = '{2'd1, 2'd1, 2'd1, 2'd0};
            end
            J_BLOCK: begin
                w_rel_x = '{2'd0, 2'd1, 2'd2, 2'd0};
                w_rel_y = '{2'd1, 2'd1, 2'd1, 2'd0};
            end
            S_BLOCK: begin
                w_rel_x = '{2'd0, 2'd1, 2'd1, 2'd2};
                w_rel_y = '{2'd1, 2'd1, 2'd0, 2'd0};
            end
            Z_BLOCK: begin
                w_rel_x = '{2'd0, 2'd1, 2'd1, 2'd2};
                w_rel_y = '{2'd0, 2'd0, 2'd1, 2'd1};
            end
            default: w_spawn_known = 1'b0;
        endcase
    end

    // Candidate coords about the pivot in modulo-1024 arithmetic; a negative result
    // wraps high and so fails the on-board test.
    always_comb begin
        logic [9:0] dx;
        logic [9:0] dy;
        w_in_bounds = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dx = r_x[i] - r_x[1];
            dy = r_y[i] - r_y[1];
            if (r_dir_cw) begin
                w_cand_x[i] = r_x[1] - dy;
                w_cand_y[i] = r_y[1] + dx;
            end else begin
                w_cand_x[i] = r_x[1] + dy;
                w_cand_y[i] = r_y[1] - dx;
            end
            if ((w_cand_x[i] >= BW) || (w_cand_y[i] >= BH)) begin
                w_in_bounds = 1'b0;
            end
        end
    end

    assign w_valid_sel = r_dir_cw ? bus.valid_cw : bus.valid_ccw;
    assign w_req       = bus.rot_cw ^ bus.rot_ccw;

    // Piece state and rotation FSM; spawn overrides and aborts any rotation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_block    <= 4'd0;
            r_rot      <= 2'd0;
            r_active   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_accepted <= 1'b0;
            r_dir_cw   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_x[i] <= 10'd0;
                r_y[i] <= 10'd0;
            end
        end else begin
            r_done <= 1'b0;
            if (bus.spawn) begin
                r_state  <= StIdle;
                r_busy   <= 1'b0;
                r_block  <= bus.spawn_block;
                r_rot    <= 2'd0;
                r_active <= w_spawn_known;
                for (int i = 0; i < 4; i++) begin
                    r_x[i] <= w_spawn_known ? SX + 10'(w_rel_x[i]) : 10'd0;
                    r_y[i] <= w_spawn_known ? 10'(w_rel_y[i]) : 10'd0;
                end
            end else begin
                case (r_state)
                    StIdle: begin
                        if (w_req && r_active) begin
                            r_dir_cw <= bus.rot_cw;
                            r_state  <= StCheck;
                            r_busy   <= 1'b1;
                        end
                    end
                    StCheck: begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                        if (w_valid_sel && w_in_bounds) begin
                            r_accepted <= 1'b1;
                            r_rot      <= r_dir_cw ? r_rot + 2'd1 : r_rot - 2'd1;
                            for (int i = 0; i < 4; i++) begin
                                r_x[i] <= w_cand_x[i];
                                r_y[i] <= w_cand_y[i];
                            end
                        end else begin
                            r_accepted <= 1'b0;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign bus.current_block = r_block;
    assign bus.ctrl_x1       = r_x[0];
    assign bus.ctrl_x2       = r_x[1];
    assign bus.ctrl_x3       = r_x[2];
    assign bus.ctrl_x4       = r_x[3];
    assign bus.ctrl_y1       = r_y[0];
    assign bus.ctrl_y2       = r_y[1];
    assign bus.ctrl_y3       = r_y[2];
    assign bus.ctrl_y4       = r_y[3];
    assign bus.rot_state     = r_rot;
    assign bus.piece_active  = r_active;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.accepted      = r_accepted;
endmodule
